shift_reg_ctrl: RTL
===================

Name: shift_reg_ctrl

Overview:
- Sequencing controller for the team's serial shift register datapath (`i_din` → `LENGTH`-stage shift → `o_dout`).
- Accepts a parallel word over a valid/ready handshake and serializes it LSB-first into the shift register.
- Captures the delayed serial stream back into a parallel word and presents it over a second valid/ready handshake.
- Pulses the shift register reset between words. Sits between a word source/sink and the shift register instance.

Parameters:
- `LENGTH`, 32, word width in bits; number of bits serialized per transaction.
- `LAT`, 32, shift register latency in cycles, ≥1: bit sampled by the shift register at edge e appears on its output after edge e+LAT-1.

Ports:
- `i_clk`  in  1  clock, all logic on rising edge
- `i_rst`  in  1  synchronous reset, active-high
- `i_word`  in  `LENGTH`  parallel word to send
- `i_word_valid`  in  1  `i_word` valid
- `o_word_ready`  out  1  controller can accept a word
- `o_sr_din`  out  1  serial data to shift register `i_din`
- `o_sr_rst`  out  1  reset to shift register `i_rst`
- `i_sr_dout`  in  1  serial data from shift register `o_dout`
- `o_rd_word`  out  `LENGTH`  captured word
- `o_rd_valid`  out  1  `o_rd_word` valid
- `i_rd_ready`  in  1  sink accepts `o_rd_word`
- `o_busy`  out  1  transaction in progress

Behaviour:
- All outputs are registered.
- Reset values while `i_rst`=1: state IDLE, `o_word_ready`=0, `o_sr_din`=0, `o_sr_rst`=1, `o_rd_valid`=0, `o_rd_word`=0, `o_busy`=0, counter=0.
- First cycle after reset release: `o_word_ready`=1, `o_sr_rst`=0.
- Counter `cnt` has width `$clog2(LAT+LENGTH+1)`.
- States: IDLE, SHIFT, DRAIN, FLUSH, DONE.
- IDLE:
  - `o_word_ready`=1.
  - Acceptance edge A occurs when `i_word_valid`&&`o_word_ready`.
  - At edge A: latch `i_word`, `cnt`←0, `o_word_ready`←0, `o_busy`←1, `o_sr_din`←`i_word[0]`, go to SHIFT.
- SHIFT:
  - While `cnt`=k (k=0..`LENGTH`-1), `o_sr_din`=word[k]. Each edge increments `cnt` and loads `o_sr_din` with the next bit.
  - After `cnt`=`LENGTH`-1 go to DRAIN; `o_sr_din`←0.
- Capture, active in SHIFT and DRAIN:
  - On each edge where `LAT` ≤ `cnt` ≤ `LAT`+`LENGTH`-1, write `i_sr_dout` into `o_rd_word[cnt-LAT]`.
  - Capture may overlap SHIFT when `LAT`<`LENGTH`.
- DRAIN: increment `cnt`. On the edge capturing `cnt`=`LAT`+`LENGTH`-1, go to FLUSH.
- FLUSH: `o_sr_rst`=1 for exactly one cycle, then go to DONE.
- DONE:
  - `o_rd_valid`=1; `o_rd_word` held stable.
  - On an edge with `i_rd_ready`=1: `o_rd_valid`←0, `o_busy`←0, `o_word_ready`←1, go to IDLE.
  - `i_rd_ready` high earlier has no effect.
- Latency: `o_rd_valid` rises `LAT`+`LENGTH`+1 edges after A. Minimum turnaround is A to the next possible acceptance = `LAT`+`LENGTH`+3 edges, assuming `i_rd_ready` is held high.
- `i_word_valid` is ignored outside IDLE; no word is dropped, because `o_word_ready`=0.
- `i_word` changes after A have no effect.
- `i_rst` mid-transaction: abort immediately, take reset values, `o_sr_rst`=1 while `i_rst`=1. No partial `o_rd_valid`.
- `o_sr_din`=0 in every state except SHIFT.

Optional Feature:
- Macro `SHIFT_REG_CTRL_CHECK_EN`.
- Defined:
  - Adds output `o_mismatch` (1) and output `o_err_count` (16).
  - On entering DONE, `o_mismatch`←(captured word ≠ latched sent word), valid while `o_rd_valid`=1.
  - `o_err_count` increments by 1 per mismatching transaction, saturates at 16'hFFFF, and is cleared only by `i_rst`. Reset value of both is 0.
- Undefined: both ports and all compare logic absent; remaining behaviour identical.

Test Plan:
- Reset:
  - Stimulus: hold `i_rst`=1 for 3 cycles, then release.
  - Required: all outputs at reset values during reset, `o_sr_rst`=1; one cycle after release `o_word_ready`=1, `o_sr_rst`=0.
- Single word:
  - Stimulus: `LENGTH`=`LAT`=32, ideal 32-flop shift register model, send 32'hA5C3_0F81, `i_rd_ready`=1.
  - Required: `o_sr_din` sequence 1,0,0,0,0,0,0,1,… LSB first; `o_rd_valid` at A+65 with `o_rd_word`=32'hA5C3_0F81; `o_sr_rst` pulses one cycle at A+64.
- Back-pressure:
  - Stimulus: send 32'h0000_0001, hold `i_rd_ready`=0 for 10 cycles after `o_rd_valid`.
  - Required: `o_rd_word` stable, `o_word_ready`=0, `i_word_valid` with 32'hFFFF_FFFF not accepted; after `i_rd_ready`=1 the next word is accepted and returns 32'hFFFF_FFFF.
- Latency sweep:
  - Stimulus: `LAT`=1 and `LAT`=40 with `LENGTH`=8, words 8'h3C and 8'hFF.
  - Required: correct words returned, `o_rd_valid` at A+`LAT`+9.
- Abort:
  - Stimulus: assert `i_rst` at `cnt`=10 of SHIFT.
  - Required: next cycle state IDLE-reset values, no `o_rd_valid`; a subsequent word 32'hDEAD_BEEF returns correctly.
- Check feature (with `SHIFT_REG_CTRL_CHECK_EN`):
  - Stimulus: model flips bit 5 of returned stream for 32'h0000_0000.
  - Required: `o_mismatch`=1, `o_err_count`=1; a following clean word gives `o_mismatch`=0, `o_err_count`=1.

Source files
------------

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: serializes a parallel word into a LAT-cycle shift register and captures it back
// Build option: define SHIFT_REG_CTRL_CHECK_EN to add loopback compare outputs.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_word/i_word_valid    parallel word in, o_word_ready accepts it
//   o_sr_din, o_sr_rst     serial data and reset towards the shift register
//   i_sr_dout              serial data back from the shift register
//   o_rd_word/o_rd_valid   captured word out, i_rd_ready accepts it
//   o_busy                 transaction in progress
//   o_mismatch, o_err_count  (option only) captured != sent flag, saturating error count
module shift_reg_ctrl #(
    parameter int LENGTH = 32,
    parameter int LAT    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [LENGTH-1:0] i_word,
    input  logic              i_word_valid,
    output logic              o_word_ready,
    output logic              o_sr_din,
    output logic              o_sr_rst,
    input  logic              i_sr_dout,
    output logic [LENGTH-1:0] o_rd_word,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic              o_busy
`ifdef SHIFT_REG_CTRL_CHECK_EN
    ,
    output logic              o_mismatch,
    output logic [15:0]       o_err_count
`endif
);
    localparam int CW = $clog2(LAT + LENGTH + 1);
    localparam logic [CW-1:0] SEND_LAST = CW'(LENGTH - 1);
    localparam logic [CW-1:0] CAP_LAST  = CW'(LAT + LENGTH - 1);
    typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, FLUSH, DONE} state_t;
    state_t            state;
    logic [CW-1:0]     cnt;
    // Rotated once per sent bit; after LENGTH rotations it holds the original word again.
    logic [LENGTH-1:0] word;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            word         <= '0;
            o_word_ready <= 1'b0;
            o_sr_din     <= 1'b0;
            o_sr_rst     <= 1'b1;
            o_rd_word    <= '0;
            o_rd_valid   <= 1'b0;
            o_busy       <= 1'b0;
`ifdef SHIFT_REG_CTRL_CHECK_EN
            o_mismatch   <= 1'b0;
            o_err_count  <= '0;
`endif
        end else begin
            // Bit k comes back while cnt == LAT+k, possibly overlapping the send phase.
            if (state == SHIFT || state == DRAIN)
                for (int i = 0; i < LENGTH; i++)
                    if (cnt == CW'(LAT + i)) o_rd_word[i] <= i_sr_dout;
            case (state)
                IDLE: begin
                    o_sr_rst <= 1'b0;
                    if (i_word_valid && o_word_ready) begin
                        word         <= i_word;
                        cnt          <= '0;
                        o_word_ready <= 1'b0;
                        o_busy       <= 1'b1;
                        o_sr_din     <= i_word[0];
                        state        <= SHIFT;
                    end else begin
                        o_word_ready <= 1'b1;
                        o_sr_din     <= 1'b0;
                    end
                end
                SHIFT: begin
                    cnt      <= cnt + 1'b1;
                    word     <= {word[0], word[LENGTH-1:1]};
                    o_sr_din <= (cnt == SEND_LAST) ? 1'b0 : word[1];
                    if (cnt == SEND_LAST) state <= DRAIN;
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CAP_LAST) begin
                        o_sr_rst <= 1'b1;
                        state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    o_sr_rst   <= 1'b0;
                    o_rd_valid <= 1'b1;
                    state      <= DONE;
`ifdef SHIFT_REG_CTRL_CHECK_EN
                    o_mismatch <= o_rd_word != word;
                    if (o_rd_word != word && o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
`endif
                end
                DONE: begin
                    if (i_rd_ready) begin
                        o_rd_valid   <= 1'b0;
                        o_busy       <= 1'b0;
                        o_word_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
